// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the 7-segment scan driver
// Purpose: hex digit segment table and digit count shared by the driver files.
// Ports: none (package).
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-high segment patterns, bit order gfedcba, indexed by nibble value.
  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display bus between the IO stage and the scan driver
// Purpose: bundles the display value/controls and the tube drive lines.
// Signals: value[31:0] number to show, dp[7:0] per-digit decimal point,
//          blank_lz leading-zero blanking enable, an[7:0] digit enables,
//          seg_out[7:0] segments {dp,g..a}.
// Modports: master drives value/dp/blank_lz; slave (driver) drives an/seg_out.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [31:0]           value;
  logic [NUM_DIGITS-1:0] dp;
  logic                  blank_lz;
  logic [NUM_DIGITS-1:0] an;
  logic [7:0]            seg_out;

  modport master (output value, output dp, output blank_lz, input an, input seg_out);
  modport slave  (input value, input dp, input blank_lz, output an, output seg_out);

endinterface

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - nibble to 7-segment pattern decoder
// Purpose: combinational lookup of the active-high gfedcba pattern for one hex digit.
// Ports: nibble_i[3:0] digit value, blank_i forces all segments off,
//        seg_o[6:0] active-high pattern (gfedcba).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = blank_i ? 7'h00 : SEG7_HEX[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 8-digit hex display driver
// Purpose: scans one digit per divider tick, showing a value snapshotted once per frame.
// Ports: clk system clock, rst asynchronous active-high reset,
//        bus (slave) value/dp/blank_lz in, an/seg_out registered out.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIV_MAX        = 99_999,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  // Keep at least one bit so DIV_MAX=0 still elaborates.
  localparam int CNT_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW  ? '1 : '0;
  localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [31:0]           shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  logic       tick;
  logic [4:0] bit_pos;
  logic [3:0] nibble;
  logic       blank;
  logic [6:0] pattern;
  logic [7:0] seg_hi;
  logic [NUM_DIGITS-1:0] an_hot;

  // Scan sequencing and frame snapshot.
  always_comb begin
    tick         = (div_cnt_q == CNT_W'(DIV_MAX));
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 3'd1 : idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    // Loading only at the 7->0 wrap keeps a whole frame coherent.
    if (tick && idx_q == 3'd7) begin
      shadow_val_d = bus.value;
      shadow_dp_d  = bus.dp;
    end
  end

  // Current-digit decode; blanked when every nibble from this digit up is zero.
  always_comb begin
    bit_pos = {idx_q, 2'b00};
    nibble  = shadow_val_q[bit_pos +: 4];
    blank   = bus.blank_lz && (idx_q != 3'd0) && ((shadow_val_q >> bit_pos) == 32'd0);
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (nibble),
    .blank_i  (blank),
    .seg_o    (pattern)
  );

  always_comb begin
    seg_hi = {shadow_dp_q[idx_q], pattern};
    seg_d  = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    an_hot = NUM_DIGITS'(1) << idx_q;
    an_d   = AN_ACTIVE_LOW ? ~an_hot : an_hot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.an      = an_q;
  assign bus.seg_out = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .DIV_MAX        (DWELL - 1),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: edge counter since reset release plus the value shown this frame.
  int          k;
  logic [31:0] m_val;
  logic [7:0]  m_dp;
  logic [6:0]  hex_tab [16];

  initial begin
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
  endtask

  function automatic logic [7:0] exp_seg(input int d, input logic blz);
    logic [31:0] upper;
    logic [3:0]  nib;
    logic [6:0]  pat;
    upper = m_val >> (4 * d);
    nib   = 4'(upper & 32'hF);
    pat   = (blz && d > 0 && upper == 32'd0) ? 7'h00 : hex_tab[nib];
    return ~{m_dp[d], pat};
  endfunction

  task automatic model_reset();
    k     = 0;
    m_val = 32'd0;
    m_dp  = 8'd0;
  endtask

  // One clock: predict the output registered at this edge, advance the model, check.
  task automatic cycle();
    int         d;
    logic [7:0] e_an, e_seg;
    @(posedge clk);
    d     = (k / DWELL) % 8;
    e_an  = ~(8'd1 << d);
    e_seg = exp_seg(d, bus.blank_lz);
    if (k % (8 * DWELL) == 8 * DWELL - 1) begin
      m_val = bus.value;
      m_dp  = bus.dp;
    end
    k++;
    #1;
    check("an", bus.an, e_an);
    check("seg_out", bus.seg_out, e_seg);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drive(input logic [31:0] v, input logic [7:0] p, input logic b);
    @(negedge clk);
    bus.value    = v;
    bus.dp       = p;
    bus.blank_lz = b;
  endtask

  initial begin
    bus.value    = 32'd0;
    bus.dp       = 8'd0;
    bus.blank_lz = 1'b0;
    model_reset();

    // Reset state, then first edge after release shows digit 0 = '0'.
    #12;
    check("reset_an", bus.an, 8'hFF);
    check("reset_seg", bus.seg_out, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_an", bus.an, 8'hFE);
    check("first_seg", bus.seg_out, 8'hC0);
    k = 1;

    // Steady value over two frames.
    drive(32'h12345678, 8'h00, 1'b0);
    run(72);

    // Mid-frame value change is deferred to the next frame.
    drive(32'h11111111, 8'h00, 1'b0);
    while (k % (8 * DWELL) != 0) cycle();
    run(8 * DWELL + 3 * DWELL);
    drive(32'h22222222, 8'h00, 1'b0);
    run(8 * DWELL + 20);

    // Leading-zero blanking.
    drive(32'h00000A05, 8'h00, 1'b1);
    run(70);
    drive(32'h00000000, 8'h00, 1'b1);
    run(70);

    // Decimal point on digit 2.
    drive(32'h00000000, 8'h04, 1'b0);
    run(70);

    // Asynchronous reset between edges at digit 5.
    drive(32'h9ABCDEF0, 8'h81, 1'b0);
    while ((k / DWELL) % 8 != 5) cycle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_an", bus.an, 8'hFF);
    check("async_rst_seg", bus.seg_out, 8'hFF);
    @(posedge clk);
    #1;
    check("held_rst_an", bus.an, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(8 * DWELL * 2 + 5);

    // Randomized values, decimal points and blanking.
    for (int i = 0; i < 40; i++) begin
      drive($urandom >> $urandom_range(31, 0), 8'($urandom), 1'($urandom));
      run($urandom_range(30, 5));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
